// File: rtl/addr_req_arbiter.sv
// Round-robin read-address arbiter: M masters share one address bus into N slaves.
// Holds at most one outstanding request and flags addresses that decode past the last slave.
module addr_req_arbiter #(
  parameter int unsigned M           = 2,
  parameter int unsigned N           = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned SLV_SEL_LSB = 28,
  parameter int unsigned LOG_M       = (M > 1) ? $clog2(M) : 1,
  parameter int unsigned LOG_N       = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [M-1:0]          m_axi_arvalid,
  output logic [M-1:0]          m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_arid    [M],
  input  logic [ADDR_WIDTH-1:0] m_axi_araddr  [M],
  input  logic [7:0]            m_axi_arlen   [M],
  input  logic [2:0]            m_axi_arsize  [M],
  input  logic [1:0]            m_axi_arburst [M],
  output logic [M-1:0]          busARVld_o,
  input  logic [N-1:0]          busARRdy_i,
  output logic [ADDR_WIDTH-1:0] busARAddr_o,
  output logic [ID_WIDTH-1:0]   busARId_o,
  output logic [7:0]            busARLen_o,
  output logic [2:0]            busARSz_o,
  output logic [1:0]            busARBurst_o,
  output logic [LOG_M-1:0]      busARSrc_o,
  output logic [LOG_N-1:0]      busARDst_o,
  output logic                  dec_err_o,
  output logic [LOG_M-1:0]      dec_err_src_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]            r_state;
  logic [LOG_M-1:0]      r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [LOG_M-1:0]      r_src;
  logic [LOG_N-1:0]      r_dst;
  logic                  r_dec_err;
  logic [LOG_M-1:0]      r_dec_err_src;

  logic                  w_grant_vld;
  logic [LOG_M-1:0]      w_grant_idx;
  logic [LOG_N-1:0]      w_sel;
  logic                  w_sel_ok;
  logic [M-1:0]          w_arready;
  logic [M-1:0]          w_bus_vld;

  // Search starts one past the previous winner and wraps, so every requester is served in turn.
  always_comb begin
    int unsigned v_idx;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    v_idx       = 0;
    for (int unsigned i = 0; i < M; i++) begin
      v_idx = (32'(r_last_grant) + 1 + i) % M;
      if (!w_grant_vld && m_axi_arvalid[v_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = LOG_M'(v_idx);
      end
    end
  end

  always_comb begin
    w_sel    = m_axi_araddr[w_grant_idx][SLV_SEL_LSB +: LOG_N];
    w_sel_ok = (32'(w_sel) < N);
  end

  always_comb begin
    w_arready = '0;
    if (!rst && (r_state == StIdle) && w_grant_vld) begin
      w_arready[w_grant_idx] = 1'b1;
    end
  end

  always_comb begin
    w_bus_vld = '0;
    if (r_state == StBusy) begin
      w_bus_vld[r_src] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_last_grant  <= LOG_M'(M - 1);
      r_addr        <= '0;
      r_id          <= '0;
      r_len         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_src         <= '0;
      r_dst         <= '0;
      r_dec_err     <= 1'b0;
      r_dec_err_src <= '0;
    end else begin
      r_dec_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_grant_vld) begin
            r_addr       <= m_axi_araddr[w_grant_idx];
            r_id         <= m_axi_arid[w_grant_idx];
            r_len        <= m_axi_arlen[w_grant_idx];
            r_size       <= m_axi_arsize[w_grant_idx];
            r_burst      <= m_axi_arburst[w_grant_idx];
            r_src        <= w_grant_idx;
            r_dst        <= w_sel;
            r_last_grant <= w_grant_idx;
            if (w_sel_ok) begin
              r_state <= StBusy;
            end else begin
              // Request is swallowed; only the error pulse reports it.
              r_dec_err     <= 1'b1;
              r_dec_err_src <= w_grant_idx;
            end
          end
        end
        StBusy: begin
          if (busARRdy_i[r_dst]) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign m_axi_arready = w_arready;
  assign busARVld_o    = w_bus_vld;
  assign busARAddr_o   = r_addr;
  assign busARId_o     = r_id;
  assign busARLen_o    = r_len;
  assign busARSz_o     = r_size;
  assign busARBurst_o  = r_burst;
  assign busARSrc_o    = r_src;
  assign busARDst_o    = r_dst;
  assign dec_err_o     = r_dec_err;
  assign dec_err_src_o = r_dec_err_src;

endmodule
